// File: rtl/ldpc_cnu_minsum.sv
// Min-sum LDPC check-node unit: serially collects one check's edges,
// then replays the extrinsic messages in arrival order.
module ldpc_cnu_minsum #(
  parameter int INT     = 8,
  parameter int FRAC    = 8,
  parameter int DEG_MAX = 6,
  parameter int LOG2DEG = 3,
  parameter int MODE    = 0,
  parameter int OFFSET  = 'h0080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INT+FRAC-1:0] in_msg,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INT+FRAC-1:0] out_msg,
  output logic [LOG2DEG-1:0] out_idx,
  output logic               out_last,
  output logic               deg_err
);

  localparam int W  = INT + FRAC;
  localparam int NE = 2 ** LOG2DEG;

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] OFF  = W'(OFFSET);
  localparam logic [LOG2DEG-1:0] KMAX = LOG2DEG'(DEG_MAX - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t state_q, state_d;

  logic [W-1:0]       min1, min2;
  logic [LOG2DEG-1:0] idx;
  logic [LOG2DEG-1:0] k;
  logic [LOG2DEG-1:0] last_j;
  logic               sgn;
  logic [NE-1:0]      sign_reg;

  logic         in_xfer, out_xfer;
  logic         in_end, overrun;
  logic [W-1:0] neg_in, mag;
  logic [W-1:0] m, mp;
  logic         s;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == EMIT);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Degree overrun forces the DEG_MAX-th edge to close the check.
  assign overrun = ~in_last & (k == KMAX);
  assign in_end  = in_last | (k == KMAX);

  assign neg_in = -in_msg;
  assign mag = !in_msg[W-1] ? in_msg :
               (in_msg == MINV) ? MAXV : neg_in;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (in_xfer && in_end) state_d = EMIT;
      EMIT:    if (out_xfer && out_last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= COLLECT;
    else      state_q <= state_d;
  end

  // k counts arriving edges in COLLECT and output edges in EMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min1     <= MAXV;
      min2     <= MAXV;
      idx      <= '0;
      k        <= '0;
      last_j   <= '0;
      sgn      <= 1'b0;
      sign_reg <= '0;
      deg_err  <= 1'b0;
    end else begin
      deg_err <= 1'b0;
      if (in_xfer) begin
        if (mag < min1) begin
          min2 <= min1;
          min1 <= mag;
          idx  <= k;
        end else if (mag < min2) begin
          min2 <= mag;
        end
        sgn         <= sgn ^ in_msg[W-1];
        sign_reg[k] <= in_msg[W-1];
        if (in_end) begin
          last_j  <= k;
          k       <= '0;
          deg_err <= overrun;
        end else begin
          k <= k + 1'b1;
        end
      end
      if (out_xfer) begin
        if (out_last) begin
          min1     <= MAXV;
          min2     <= MAXV;
          idx      <= '0;
          k        <= '0;
          sgn      <= 1'b0;
          sign_reg <= '0;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  assign m = (k == idx) ? min2 : min1;
  assign s = sgn ^ sign_reg[k];

  always_comb begin
    mp = m - (m >> 2);
    if (MODE == 0) mp = (m > OFF) ? (m - OFF) : '0;
  end

  // Outputs are pure functions of held state, so they stay put under stall.
  assign out_msg  = out_valid ? (s ? -mp : mp) : '0;
  assign out_idx  = out_valid ? k : '0;
  assign out_last = out_valid & (k == last_j);

endmodule
